// File: rtl/fifo_reader.sv
// fifo_reader
//   Pulls words out of a 1-cycle-latency FIFO and presents them as a
//   valid/ready stream through a small skid buffer.
//
//   Ports
//     clk, rst      single clock, synchronous active-high reset
//     en            run enable; high permits new FIFO reads
//     fifo_empty    FIFO empty flag
//     fifo_data     FIFO read data, valid the cycle after an accepted read
//     fifo_rd_en    FIFO read strobe
//     m_valid       stream word available (buffer not empty)
//     m_ready       downstream accepts word
//     m_data        stream data (buffer head)
//     busy          controller not idle
//     rd_count      words delivered downstream, wraps at 16 bits
module fifo_reader #(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [15:0]       rd_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_occ;
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic              r_inflight;
  logic [15:0]       r_rd_count;
  logic [DATA_W-1:0] r_buf [0:BUF_DEPTH-1];

  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_pending;
  logic [1:0]        w_occ_nxt;

  // Words already committed to the buffer: stored plus the one on the
  // FIFO read bus. Issuing a read only when this is below the depth
  // guarantees a slot for every returning word, so the strobe never needs
  // to look at m_ready.
  assign w_pending  = {1'b0, r_occ} + {2'b00, r_inflight};

  assign fifo_rd_en = !rst && (r_state == S_RUN) && en && !fifo_empty &&
                      (w_pending < 3'(BUF_DEPTH));

  assign m_valid    = !rst && (r_occ != 2'd0);
  assign m_data     = r_buf[r_rptr];
  assign busy       = !rst && (r_state != S_IDLE);
  assign rd_count   = r_rd_count;

  // A read accepted last cycle lands in the buffer this edge.
  assign w_push     = r_inflight;
  assign w_pop      = m_valid && m_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Controller
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // Re-enable wins over finishing the drain. A pop on the last
        // buffered word counts as empty, hence the next-occupancy test.
        if (en)
          w_state_nxt = S_RUN;
        else if (!r_inflight && (w_occ_nxt == 2'd0))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Skid-buffer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_inflight <= 1'b0;
      r_rd_count <= 16'd0;
    end else begin
      r_occ      <= w_occ_nxt;
      // Reads only issue while running, so draining never starts a new one;
      // a read already on the bus still completes via w_push.
      r_inflight <= fifo_rd_en;
      if (w_push)
        r_wptr <= (r_wptr == 2'(BUF_DEPTH - 1)) ? 2'd0 : r_wptr + 2'd1;
      if (w_pop) begin
        r_rptr     <= (r_rptr == 2'(BUF_DEPTH - 1)) ? 2'd0 : r_rptr + 2'd1;
        r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push)
      r_buf[r_wptr] <= fifo_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_occ == 2'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: environment FIFO as a queue, reference model as a
// queue of words owed downstream plus an in-flight flag and a run mode.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data = 16'd0;
  logic        m_ready = 1'b0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        busy;
  logic [15:0] rd_count;

  fifo_reader #(.DATA_W(16), .BUF_DEPTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  int n_tests = 0;
  int n_fail  = 0;

  // environment
  logic [15:0] src[$];
  logic [15:0] pend;
  bit          stall = 0;
  // reference model
  int          mode = M_IDLE;
  bit          inf = 0;
  logic [15:0] got[$];
  logic [15:0] mcount = 16'd0;
  bit          armed = 0;
  // observations
  logic [15:0] obs[$];
  bit          rec = 1;
  int          n_rd = 0;
  int          n_pop = 0;
  int          run_v = 0;
  int          max_run = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, o, e, $time);
    end
  endtask

  // One clock cycle: check outputs against the model, advance both.
  task automatic step();
    bit e_rd, e_v, acc, pop_m;
    logic [15:0] cap;
    fifo_empty = (src.size() == 0) || stall;
    #1;
    e_rd  = !rst && (mode == M_RUN) && en && !fifo_empty && ((got.size() + int'(inf)) < 3);
    e_v   = !rst && (got.size() != 0);
    pop_m = e_v && m_ready;
    chk("rd_en",   32'(fifo_rd_en), 32'(e_rd));
    chk("m_valid", 32'(m_valid),    32'(e_v));
    chk("busy",    32'(busy),       32'(!rst && (mode != M_IDLE)));
    if (armed) chk("rd_count", 32'(rd_count), 32'(mcount));
    if (e_v)   chk("m_data",   32'(m_data),   32'(got[0]));
    acc = fifo_rd_en && !fifo_empty;
    if (acc) begin
      n_rd++;
      pend = src.pop_front();
    end
    if (m_valid) begin
      run_v++;
      if (run_v > max_run) max_run = run_v;
    end else begin
      run_v = 0;
    end
    if (m_valid && m_ready) begin
      n_pop++;
      if (rec) obs.push_back(m_data);
    end
    cap = fifo_data;
    @(posedge clk);
    if (rst) begin
      mode = M_IDLE; got.delete(); inf = 0; mcount = 16'd0; armed = 1;
    end else begin
      if (pop_m) begin
        void'(got.pop_front());
        mcount = mcount + 16'd1;
      end
      if (inf) got.push_back(cap);
      case (mode)
        M_IDLE:  if (en) mode = M_RUN;
        M_RUN:   if (!en) mode = M_DRAIN;
        default: if (en) mode = M_RUN;
                 else if (!inf && got.size() == 0) mode = M_IDLE;
      endcase
      inf = e_rd;
    end
    #1;
    fifo_data = acc ? pend : 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1; en = 0; m_ready = 0; stall = 0;
    step();
    rst = 0;
    src.delete(); obs.delete();
    n_rd = 0; n_pop = 0; run_v = 0; max_run = 0;
  endtask

  task automatic drain(input string tag);
    en = 0; m_ready = 1;
    for (int i = 0; i < 40 && (busy || m_valid); i++) step();
    chk({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic load_to_full();
    // IDLE->RUN, then three reads with no pops: 2 buffered + 1 in flight
    en = 1; m_ready = 0;
    repeat (4) step();
  endtask

  initial begin
    logic [15:0] exp_w[$];

    // reset state
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
    chk("rst_valid", 32'(m_valid),  32'(0));
    chk("rst_busy",  32'(busy),     32'(0));
    chk("rst_count", 32'(rd_count), 32'(0));

    // basic order
    do_reset();
    src = '{16'hABCD, 16'h1234};
    en = 1; m_ready = 1;
    repeat (8) step();
    chk("basic_n",     32'(obs.size()), 32'(2));
    chk("basic_w0",    32'(obs[0]),     32'hABCD);
    chk("basic_w1",    32'(obs[1]),     32'h1234);
    chk("basic_run",   32'(max_run),    32'(2));
    chk("basic_count", 32'(rd_count),   32'(2));
    drain("basic");

    // backpressure
    do_reset();
    src = '{16'h5678, 16'h9ABC, 16'h1111, 16'h2222};
    en = 1; m_ready = 0;
    repeat (8) step();
    chk("bp_reads", 32'(n_rd),       32'(3));
    chk("bp_rden",  32'(fifo_rd_en), 32'(0));
    chk("bp_valid", 32'(m_valid),    32'(1));
    m_ready = 1;
    repeat (8) step();
    exp_w = '{16'h5678, 16'h9ABC, 16'h1111, 16'h2222};
    chk("bp_n", 32'(obs.size()), 32'(4));
    for (int i = 0; i < 4 && i < obs.size(); i++) chk("bp_word", 32'(obs[i]), 32'(exp_w[i]));
    drain("bp");

    // streaming 64 words
    do_reset();
    for (int i = 0; i < 64; i++) src.push_back(16'(i * 7 + 3));
    en = 1; m_ready = 1;
    repeat (75) step();
    chk("stream_run",   32'(max_run),  32'(64));
    chk("stream_count", 32'(rd_count), 32'(64));
    for (int i = 0; i < 64 && i < obs.size(); i++) chk("stream_word", 32'(obs[i]), 32'(i * 7 + 3));
    drain("stream");

    // drain with 1 in flight and 2 buffered
    do_reset();
    for (int i = 0; i < 10; i++) src.push_back(16'(16'hD000 + i));
    load_to_full();
    n_rd = 0; obs.delete();
    en = 0; m_ready = 1;
    repeat (8) step();
    chk("drain_reads", 32'(n_rd),       32'(0));
    chk("drain_n",     32'(obs.size()), 32'(3));
    chk("drain_busy",  32'(busy),       32'(0));
    for (int i = 0; i < 3 && i < obs.size(); i++) chk("drain_word", 32'(obs[i]), 32'(16'hD000 + i));

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 10; i++) src.push_back(16'(16'hE000 + i));
    load_to_full();
    obs.delete();
    rst = 1;
    step();
    rst = 0; en = 0; m_ready = 1;
    #1;
    chk("mid_valid", 32'(m_valid),  32'(0));
    chk("mid_count", 32'(rd_count), 32'(0));
    chk("mid_busy",  32'(busy),     32'(0));
    repeat (5) step();
    chk("mid_none", 32'(obs.size()), 32'(0));

    // counter wrap and long pointer wrap
    do_reset();
    for (int i = 0; i < 65536; i++) src.push_back(16'($urandom));
    rec = 0; en = 1; m_ready = 1;
    for (int i = 0; i < 66000 && n_pop < 65535; i++) step();
    chk("wrap_ffff", 32'(rd_count), 32'hFFFF);
    for (int i = 0; i < 10 && n_pop < 65536; i++) step();
    chk("wrap_zero", 32'(rd_count), 32'(0));
    drain("wrap");
    rec = 1;

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 15) == 0) en = !en;
      m_ready = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      if (src.size() < 4 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 6)) src.push_back(16'($urandom));
      step();
    end
    rst = 0; stall = 0;
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
